// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared state encoding, defaults and burst clamp for the SDRAM arbiter
package sdram_arbiter_pkg;
    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;
    localparam int BURST_MAX  = 256;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_e;

    function automatic logic [8:0] clamp_burst(input logic [9:0] b);
        return b == 10'd0 ? 9'd1 : (int'(b) > BURST_MAX ? 9'(BURST_MAX) : b[8:0]);
    endfunction
endpackage

// File: rtl/sdram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; ptr_i names the port that wins a tie
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);
    always_comb gnt_o = &req_i ? {ptr_i, ~ptr_i} : req_i;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin front end for a burst SDRAM controller
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [9:0]        p0_burst,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_wr_next,
    output logic              p0_rd_valid,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [9:0]        p1_burst,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_wr_next,
    output logic              p1_rd_valid,
    output logic              p1_done,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [9:0]        sdram_wr_burst,
    output logic [9:0]        sdram_rd_burst,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_wdata,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    input  logic [DATA_W-1:0] sdram_rdata,
    input  logic              sdram_init_done,
    input  logic              about_to_refresh,
    input  logic              idle
);
    state_e            state_q;
    logic              ptr_q, we_q, wr_req_q, rd_req_q;
    logic [1:0]        gnt_q, win_d;
    logic [8:0]        cnt_q, burst_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              start_d, ack_d, sel_we_d;

    rr_arb2 u_rr (
        .req_i ({p1_req, p0_req}),
        .ptr_i (ptr_q),
        .gnt_o (win_d)
    );

    always_comb begin
        start_d  = state_q == S_IDLE && (p0_req || p1_req) && sdram_init_done && idle && !about_to_refresh;
        ack_d    = we_q ? sdram_wr_ack : sdram_rd_ack;
        cnt_d    = cnt_q + {8'd0, ack_d};
        sel_we_d = win_d[1] ? p1_we : p0_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            burst_q  <= '0;
            gnt_q    <= '0;
            we_q     <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start_d) begin
                    state_q  <= S_REQ;
                    gnt_q    <= win_d;
                    we_q     <= sel_we_d;
                    wr_req_q <= sel_we_d;
                    rd_req_q <= !sel_we_d;
                    addr_q   <= win_d[1] ? p1_addr : p0_addr;
                    burst_q  <= clamp_burst(win_d[1] ? p1_burst : p0_burst);
                    cnt_q    <= '0;
                end
                S_REQ: if (ack_d) begin
                    cnt_q    <= cnt_d;
                    wr_req_q <= 1'b0;
                    rd_req_q <= 1'b0;
                    state_q  <= cnt_d == burst_q ? S_DONE : S_XFER;
                end
                S_XFER: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == burst_q) state_q <= S_DONE;
                end
                S_DONE: if (idle) begin
                    // next tie goes to whichever port was not just served
                    ptr_q   <= ~gnt_q[1];
                    gnt_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        p0_gnt         = gnt_q[0];
        p1_gnt         = gnt_q[1];
        p0_wr_next     = gnt_q[0] && we_q && sdram_wr_ack;
        p1_wr_next     = gnt_q[1] && we_q && sdram_wr_ack;
        p0_rd_valid    = gnt_q[0] && !we_q && sdram_rd_ack;
        p1_rd_valid    = gnt_q[1] && !we_q && sdram_rd_ack;
        p0_done        = gnt_q[0] && state_q == S_DONE && idle;
        p1_done        = gnt_q[1] && state_q == S_DONE && idle;
        sdram_wr_req   = wr_req_q;
        sdram_rd_req   = rd_req_q;
        sdram_wr_burst = {1'b0, burst_q};
        sdram_rd_burst = {1'b0, burst_q};
        sdram_addr     = addr_q;
        sdram_wdata    = gnt_q[1] ? p1_wdata : (gnt_q[0] ? p0_wdata : '0);
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of the arbiter against a transaction-level model
module tb_sdram_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [23:0] p0_addr = 0, p1_addr = 0;
    logic [9:0]  p0_burst = 0, p1_burst = 0;
    logic [15:0] p0_wdata = 0, p1_wdata = 0, sdram_rdata = 0;
    logic        p0_gnt, p0_wr_next, p0_rd_valid, p0_done;
    logic        p1_gnt, p1_wr_next, p1_rd_valid, p1_done;
    logic        sdram_wr_req, sdram_rd_req;
    logic [9:0]  sdram_wr_burst, sdram_rd_burst;
    logic [23:0] sdram_addr;
    logic [15:0] sdram_wdata;
    logic        sdram_wr_ack = 0, sdram_rd_ack = 0, sdram_init_done = 1, about_to_refresh = 0, idle = 1;
    int          tests = 0, failed = 0;
    bit          favour = 0;

    sdram_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_burst(p0_burst), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_wr_next(p0_wr_next), .p0_rd_valid(p0_rd_valid), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_burst(p1_burst), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_wr_next(p1_wr_next), .p1_rd_valid(p1_rd_valid), .p1_done(p1_done),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdram_wr_burst(sdram_wr_burst), .sdram_rd_burst(sdram_rd_burst),
        .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack), .sdram_rdata(sdram_rdata),
        .sdram_init_done(sdram_init_done), .about_to_refresh(about_to_refresh), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{p0_gnt, p0_wr_next, p0_rd_valid, p0_done, p1_gnt, p1_wr_next, p1_rd_valid, p1_done,
                 sdram_wr_req, sdram_rd_req, sdram_wr_burst, sdram_rd_burst, sdram_addr, sdram_wdata};
    endfunction
    function automatic logic gnt_of(input int p);  return p != 0 ? p1_gnt : p0_gnt;  endfunction
    function automatic logic done_of(input int p); return p != 0 ? p1_done : p0_done; endfunction
    function automatic logic wn_of(input int p);   return p != 0 ? p1_wr_next : p0_wr_next; endfunction
    function automatic logic rv_of(input int p);   return p != 0 ? p1_rd_valid : p0_rd_valid; endfunction
    function automatic logic all_of(input int p);
        return gnt_of(p) | done_of(p) | wn_of(p) | rv_of(p);
    endfunction

    task automatic set_port(input int p, input bit we, input logic [23:0] addr, input int burst);
        if (p != 0) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_burst = 10'(burst); end
        else begin p0_req = 1; p0_we = we; p0_addr = addr; p0_burst = 10'(burst); end
    endtask

    // Plays the SDRAM controller for one transaction and checks the arbiter's view of it.
    task automatic serve(input int port, input bit we, input logic [23:0] addr, input int burst, input bit keep);
        int nb, n, st, oth, rqb, wdb, dn, got;
        bit a;
        nb = burst == 0 ? 1 : (burst > 256 ? 256 : burst);
        n = 0; st = 0; oth = 0; rqb = 0; wdb = 0; dn = 0; got = 0;
        while (!(p0_gnt || p1_gnt) && n < 100) begin step(); n++; end
        chk("grant_wait", 32'(n < 100), 1);
        chk("grant_port", 32'({p1_gnt, p0_gnt}), port != 0 ? 2 : 1);
        chk("sdram_addr", 32'(sdram_addr), 32'(addr));
        chk("burst_out", 32'(we ? sdram_wr_burst : sdram_rd_burst), 32'(nb));
        chk("req_line", 32'({sdram_wr_req, sdram_rd_req}), we ? 2 : 1);
        if (port != 0) begin p1_addr = 24'($urandom); p1_burst = 10'($urandom); p1_we = ~we; end
        else begin p0_addr = 24'($urandom); p0_burst = 10'($urandom); p0_we = ~we; end
        idle = 0;
        repeat ($urandom_range(0, 3)) step();
        chk("req_held", 32'({sdram_wr_req, sdram_rd_req}), we ? 2 : 1);
        chk("addr_latched", 32'(sdram_addr), 32'(addr));
        while (got < nb) begin
            @(negedge clk);
            a = got == 0 || $urandom_range(0, 3) != 0;
            p0_wdata = 16'($urandom);
            p1_wdata = 16'($urandom);
            sdram_rdata = 16'($urandom);
            sdram_wr_ack = we & a;
            sdram_rd_ack = !we & a;
            #1;
            st  += int'(we ? wn_of(port) : rv_of(port));
            oth += int'(all_of(1 - port)) + int'(we ? rv_of(port) : wn_of(port)) + int'(done_of(port));
            if (got > 0) rqb += int'(sdram_wr_req | sdram_rd_req);
            if (a && we && sdram_wdata !== (port != 0 ? p1_wdata : p0_wdata)) wdb++;
            if (a) got++;
        end
        @(negedge clk);
        sdram_wr_ack = 0;
        sdram_rd_ack = 0;
        #1;
        rqb += int'(sdram_wr_req | sdram_rd_req);
        chk("strobe_count", 32'(st), 32'(nb));
        chk("stray_outputs", 32'(oth), 0);
        chk("req_after_ack", 32'(rqb), 0);
        chk("wdata_mux", 32'(wdb), 0);
        repeat ($urandom_range(0, 3)) begin step(); dn += int'(p0_done | p1_done); end
        chk("done_while_busy", 32'(dn), 0);
        idle = 1;
        #1;
        n = 0;
        while (!done_of(port) && n < 10) begin step(); n++; end
        chk("done_latency", 32'(n), 0);
        chk("gnt_at_done", 32'({gnt_of(port), all_of(1 - port)}), 2);
        if (!keep) begin if (port != 0) p1_req = 0; else p0_req = 0; end
        step();
        chk("done_one_cycle", 32'({gnt_of(port), done_of(port)}), 0);
        favour = port == 0;
    endtask

    initial begin
        int n, bad, m, w;
        bit we0, we1;
        int b0, b1;
        logic [23:0] a0, a1;
        repeat (3) step();
        chk("reset_outputs", 32'(any_out()), 0);
        rst = 0;
        step();
        chk("idle_outputs", 32'(any_out()), 0);

        // single read, burst 8
        set_port(0, 0, 24'h000100, 8);
        serve(0, 0, 24'h000100, 8, 0);

        // simultaneous requests right after reset, then an immediate re-request from p0
        rst = 1; step(); rst = 0; favour = 0;
        set_port(0, 1, 24'h00abcd, 4);
        set_port(1, 0, 24'h123456, 2);
        serve(0, 1, 24'h00abcd, 4, 1);
        set_port(0, 0, 24'h0000ff, 3);
        serve(1, 0, 24'h123456, 2, 0);
        serve(0, 0, 24'h0000ff, 3, 0);

        // request held off by an imminent refresh
        about_to_refresh = 1;
        set_port(1, 1, 24'h777777, 5);
        bad = 0;
        repeat (10) begin step(); bad += int'(p1_gnt | p0_gnt | sdram_wr_req | sdram_rd_req); end
        chk("refresh_block", 32'(bad), 0);
        about_to_refresh = 0;
        serve(1, 1, 24'h777777, 5, 0);

        // burst 0 becomes one word
        set_port(0, 1, 24'h000042, 0);
        serve(0, 1, 24'h000042, 0, 0);

        // randomized traffic against the round-robin model
        for (int t = 0; t < 20; t++) begin
            m = $urandom_range(1, 3);
            we0 = 1'($urandom); we1 = 1'($urandom);
            a0 = 24'($urandom); a1 = 24'($urandom);
            b0 = $urandom_range(0, 9) == 0 ? $urandom_range(250, 400) : $urandom_range(0, 12);
            b1 = $urandom_range(0, 9) == 0 ? $urandom_range(250, 400) : $urandom_range(0, 12);
            if (m[0]) set_port(0, we0, a0, b0);
            if (m[1]) set_port(1, we1, a1, b1);
            while (m != 0) begin
                w = m == 3 ? int'(favour) : (m == 2 ? 1 : 0);
                if (w != 0) serve(1, we1, a1, b1, 0); else serve(0, we0, a0, b0, 0);
                m = m & ~(1 << w);
            end
        end

        // reset in the middle of a long read
        set_port(0, 1, 24'h000010, 3);
        serve(0, 1, 24'h000010, 3, 0);
        set_port(0, 0, 24'h000200, 256);
        n = 0;
        while (!p0_gnt && n < 50) begin step(); n++; end
        chk("long_grant", 32'(n < 50), 1);
        idle = 0;
        repeat (5) begin @(negedge clk); sdram_rd_ack = 1; end
        @(negedge clk);
        rst = 1;
        step();
        chk("mid_reset_outputs", 32'(any_out()), 0);
        rst = 0; sdram_rd_ack = 0; idle = 1; p0_req = 0; favour = 0;
        step();
        set_port(0, 1, 24'h000300, 2);
        set_port(1, 1, 24'h000400, 2);
        serve(0, 1, 24'h000300, 2, 0);
        serve(1, 1, 24'h000400, 2, 0);

        // controller not initialised
        sdram_init_done = 0;
        rst = 1; step(); rst = 0; favour = 0;
        set_port(0, 0, 24'h000500, 1);
        set_port(1, 1, 24'h000600, 1);
        bad = 0;
        repeat (100) begin step(); bad += int'(p1_gnt | p0_gnt | sdram_wr_req | sdram_rd_req); end
        chk("init_block", 32'(bad), 0);
        @(negedge clk);
        sdram_init_done = 1;
        step();
        chk("init_grant", 32'({p1_gnt, p0_gnt}), 1);
        serve(0, 0, 24'h000500, 1, 0);
        serve(1, 1, 24'h000600, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
